// File: rtl/vga_rgb_pkg.sv
// rtl/vga_rgb_pkg.sv - shared types and bar colour table for the VGA RGB mode mux
//
// Purpose: the picture-source mode enum, the 3-bit {R,G,B} on/off codes for the
// eight colour bars, and small helpers used by the mux and its fade generator.
// Ports: none (package).

package vga_rgb_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_FADE    = 2'd3
    } mode_e;

    // Bar colours as {R,G,B}: a set bit drives that channel to all ones.
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = BAR_WHITE;
            3'd1:    rgb = BAR_YELLOW;
            3'd2:    rgb = BAR_CYAN;
            3'd3:    rgb = BAR_GREEN;
            3'd4:    rgb = BAR_MAGENTA;
            3'd5:    rgb = BAR_RED;
            3'd6:    rgb = BAR_BLUE;
            default: rgb = BAR_BLACK;
        endcase
        return rgb;
    endfunction

    // Modes wrap FADE -> SOLID through the natural 2-bit overflow.
    function automatic mode_e mode_succ(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/vga_rgb_mode_mux_if.sv
// rtl/vga_rgb_mode_mux_if.sv - timing/switch inputs and colour outputs of the RGB mode mux
//
// Purpose: bundles the timing-generator inputs, switch colour, and colour/mode
// outputs. master = the timing/board side driving inputs, slave = the mux.
// Signals: mode_next, frame_tick, DE, x_pixel, y_pixel, sw_red/green/blue (to mux);
//          red_port, green_port, blue_port, mode (from mux).

interface vga_rgb_mode_mux_if #(
    parameter int COLOR_W = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 10
);
    logic               mode_next;
    logic               frame_tick;
    logic               DE;
    logic [X_W-1:0]     x_pixel;
    logic [Y_W-1:0]     y_pixel;
    logic [COLOR_W-1:0] sw_red;
    logic [COLOR_W-1:0] sw_green;
    logic [COLOR_W-1:0] sw_blue;
    logic [COLOR_W-1:0] red_port;
    logic [COLOR_W-1:0] green_port;
    logic [COLOR_W-1:0] blue_port;
    logic [1:0]         mode;

    modport master (
        output mode_next, frame_tick, DE, x_pixel, y_pixel, sw_red, sw_green, sw_blue,
        input  red_port, green_port, blue_port, mode
    );

    modport slave (
        input  mode_next, frame_tick, DE, x_pixel, y_pixel, sw_red, sw_green, sw_blue,
        output red_port, green_port, blue_port, mode
    );
endinterface

// File: rtl/vga_fade_gen.sv
// rtl/vga_fade_gen.sv - frame divider and triangle brightness level for FADE mode
//
// Purpose: steps a COLOR_W-bit level 0..max..0 once every FADE_DIV frame ticks.
// Ports: clk, reset (sync, active-high), enable (count ticks), restart (force
//        level 0 / up / divider 0), frame_tick, level (current brightness).

module vga_fade_gen
    import vga_rgb_pkg::*;
#(
    parameter int COLOR_W  = 4,
    parameter int FADE_DIV = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               restart,
    input  logic               frame_tick,
    output logic [COLOR_W-1:0] level
);
    localparam int                 DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [COLOR_W-1:0] LVL_MAX  = '1;

    logic [DIV_W-1:0]   r_div;
    logic [COLOR_W-1:0] r_level;
    logic               r_dir_down;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_div      <= '0;
            r_level    <= '0;
            r_dir_down <= 1'b0;
        end else if (enable && frame_tick) begin
            if (r_div == DIV_LAST) begin
                r_div <= '0;
                // Turn-around points step away from the end so max and 0 are
                // each shown for only one step.
                if (!r_dir_down) begin
                    if (r_level == LVL_MAX) begin
                        r_dir_down <= 1'b1;
                        r_level    <= LVL_MAX - COLOR_W'(1);
                    end else begin
                        r_level <= r_level + COLOR_W'(1);
                    end
                end else begin
                    if (r_level == '0) begin
                        r_dir_down <= 1'b0;
                        r_level    <= COLOR_W'(1);
                    end else begin
                        r_level <= r_level - COLOR_W'(1);
                    end
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign level = r_level;

endmodule

// File: rtl/vga_rgb_mode_mux.sv
// rtl/vga_rgb_mode_mux.sv - selectable-source registered RGB output stage
//
// Purpose: drives the VGA colour pins from SOLID / BARS / CHECKER / FADE,
// switching modes only on frame_tick so frames never tear. One cycle latency.
// Ports: clk, reset (sync, active-high), bus (slave modport: timing inputs,
//        switch colour in; red/green/blue_port and mode out).

module vga_rgb_mode_mux
    import vga_rgb_pkg::*;
#(
    parameter int COLOR_W     = 4,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int H_ACT       = 640,
    parameter int CHECK_SHIFT = 5,
    parameter int FADE_DIV    = 2
) (
    input  logic                clk,
    input  logic                reset,
    vga_rgb_mode_mux_if.slave   bus
);
    localparam int BAND = H_ACT / 8;

    // ---------------- mode_next edge detect ----------------
    // r_armed blocks an edge until mode_next has been seen low since reset, so a
    // level held high through reset does not count as a new request.
    logic r_mn_q;
    logic r_armed;
    logic w_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mn_q  <= 1'b0;
            r_armed <= ~bus.mode_next;
        end else begin
            r_mn_q <= bus.mode_next;
            if (!bus.mode_next) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_edge = bus.mode_next & ~r_mn_q & r_armed;

    // ---------------- mode FSM ----------------
    mode_e r_mode;
    mode_e w_mode_nxt;
    logic  r_pending;
    logic  w_pending_nxt;
    logic  w_advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode    <= MODE_SOLID;
            r_pending <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_mode_nxt    = r_mode;
        w_pending_nxt = r_pending;
        w_advance     = 1'b0;
        if (bus.frame_tick && (r_pending || w_edge)) begin
            w_advance     = 1'b1;
            w_mode_nxt    = mode_succ(r_mode);
            w_pending_nxt = 1'b0;
        end else if (w_edge) begin
            w_pending_nxt = 1'b1;
        end
    end

    // ---------------- fade level ----------------
    logic [COLOR_W-1:0] w_level;
    logic               w_fade_restart;

    assign w_fade_restart = w_advance && (w_mode_nxt == MODE_FADE);

    vga_fade_gen #(
        .COLOR_W  (COLOR_W),
        .FADE_DIV (FADE_DIV)
    ) u_fade (
        .clk        (clk),
        .reset      (reset),
        .enable     (r_mode == MODE_FADE),
        .restart    (w_fade_restart),
        .frame_tick (bus.frame_tick),
        .level      (w_level)
    );

    // ---------------- sources ----------------
    // Bar index counts how many band boundaries x has passed; columns past the
    // last boundary stay in bar 7.
    logic [2:0] w_bar;
    logic [2:0] w_bar_rgb;

    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(bus.x_pixel) >= k * BAND) begin
                w_bar = 3'(k);
            end
        end
    end

    assign w_bar_rgb = bar_rgb(w_bar);

    logic [2*COLOR_W-1:0] w_prod_r;
    logic [2*COLOR_W-1:0] w_prod_g;
    logic [2*COLOR_W-1:0] w_prod_b;

    assign w_prod_r = {{COLOR_W{1'b0}}, bus.sw_red}   * {{COLOR_W{1'b0}}, w_level};
    assign w_prod_g = {{COLOR_W{1'b0}}, bus.sw_green} * {{COLOR_W{1'b0}}, w_level};
    assign w_prod_b = {{COLOR_W{1'b0}}, bus.sw_blue}  * {{COLOR_W{1'b0}}, w_level};

    logic [COLOR_W-1:0] w_red;
    logic [COLOR_W-1:0] w_green;
    logic [COLOR_W-1:0] w_blue;

    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        if (bus.DE) begin
            case (r_mode)
                MODE_SOLID: begin
                    w_red   = bus.sw_red;
                    w_green = bus.sw_green;
                    w_blue  = bus.sw_blue;
                end
                MODE_BARS: begin
                    w_red   = {COLOR_W{w_bar_rgb[2]}};
                    w_green = {COLOR_W{w_bar_rgb[1]}};
                    w_blue  = {COLOR_W{w_bar_rgb[0]}};
                end
                MODE_CHECKER: begin
                    if (bus.x_pixel[CHECK_SHIFT] ^ bus.y_pixel[CHECK_SHIFT]) begin
                        w_red   = bus.sw_red;
                        w_green = bus.sw_green;
                        w_blue  = bus.sw_blue;
                    end else begin
                        w_red   = ~bus.sw_red;
                        w_green = ~bus.sw_green;
                        w_blue  = ~bus.sw_blue;
                    end
                end
                MODE_FADE: begin
                    w_red   = w_prod_r[2*COLOR_W-1:COLOR_W];
                    w_green = w_prod_g[2*COLOR_W-1:COLOR_W];
                    w_blue  = w_prod_b[2*COLOR_W-1:COLOR_W];
                end
                default: begin
                    w_red   = '0;
                    w_green = '0;
                    w_blue  = '0;
                end
            endcase
        end
    end

    // ---------------- output register ----------------
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_red   <= w_red;
            r_green <= w_green;
            r_blue  <= w_blue;
        end
    end

    assign bus.red_port   = r_red;
    assign bus.green_port = r_green;
    assign bus.blue_port  = r_blue;
    assign bus.mode       = r_mode;

endmodule

// File: tb/tb_vga_rgb_mode_mux.sv
// tb/tb_vga_rgb_mode_mux.sv - self-checking bench for vga_rgb_mode_mux

module tb_vga_rgb_mode_mux;
    localparam int CW       = 4;
    localparam int H_ACT    = 640;
    localparam int CS       = 5;
    localparam int FADE_DIV = 2;
    localparam int MAXC     = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_rgb_mode_mux_if #(.COLOR_W(CW), .X_W(10), .Y_W(10)) bus ();

    vga_rgb_mode_mux #(
        .COLOR_W(CW), .X_W(10), .Y_W(10), .H_ACT(H_ACT), .CHECK_SHIFT(CS), .FADE_DIV(FADE_DIV)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int bar_r [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    int bar_g [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int bar_b [8] = '{1, 0, 1, 0, 1, 0, 1, 0};

    // Triangle wave over fade steps: 0..MAXC..1 repeating with period 2*MAXC.
    function automatic int tri_level(input int steps);
        int p;
        p = steps % (2 * MAXC);
        return (p <= MAXC) ? p : (2 * MAXC - p);
    endfunction

    function automatic int src(input int mode, input int lvl, input int de, input int x,
                               input int y, input int sw, input int bar_on);
        if (!de) return 0;
        case (mode)
            0: return sw;
            1: return bar_on ? MAXC : 0;
            2: return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? sw : (MAXC - sw);
            default: return (sw * lvl) >> CW;
        endcase
    endfunction

    int m_mode, m_pending, m_prev_mn, m_fade_ticks, m_steps;
    int e_r, e_g, e_b;
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        int de, x, y, mn, tk, bar, lvl, edge_seen;
        de = bus.DE; x = bus.x_pixel; y = bus.y_pixel;
        mn = bus.mode_next; tk = bus.frame_tick;
        if (reset) begin
            e_r = 0; e_g = 0; e_b = 0;
            m_mode = 0; m_pending = 0; m_prev_mn = mn;
            m_fade_ticks = 0; m_steps = 0;
        end else begin
            bar = x / (H_ACT / 8);
            if (bar > 7) bar = 7;
            lvl = tri_level(m_steps);
            e_r = src(m_mode, lvl, de, x, y, bus.sw_red,   bar_r[bar]);
            e_g = src(m_mode, lvl, de, x, y, bus.sw_green, bar_g[bar]);
            e_b = src(m_mode, lvl, de, x, y, bus.sw_blue,  bar_b[bar]);
            edge_seen = mn && !m_prev_mn;
            m_prev_mn = mn;
            if (tk && m_mode == 3) begin
                m_fade_ticks++;
                if (m_fade_ticks % FADE_DIV == 0) m_steps++;
            end
            if (tk && (m_pending || edge_seen)) begin
                m_mode = (m_mode + 1) % 4;
                m_pending = 0;
                if (m_mode == 3) begin
                    m_fade_ticks = 0;
                    m_steps = 0;
                end
            end else if (edge_seen) begin
                m_pending = 1;
            end
        end
        model_valid = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (model_valid) begin
            check("model_red",   bus.red_port,   e_r);
            check("model_green", bus.green_port, e_g);
            check("model_blue",  bus.blue_port,  e_b);
            check("model_mode",  bus.mode,       m_mode);
        end
    end

    // ---------------- stimulus ----------------
    task automatic go();
        @(negedge clk);
    endtask

    task automatic set_sw(input int r, input int g, input int b);
        bus.sw_red = r[CW-1:0]; bus.sw_green = g[CW-1:0]; bus.sw_blue = b[CW-1:0];
    endtask

    task automatic check_rgb(input string name, input int r, input int g, input int b);
        check({name, "_r"}, bus.red_port,   r);
        check({name, "_g"}, bus.green_port, g);
        check({name, "_b"}, bus.blue_port,  b);
    endtask

    task automatic tick_frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1; go();
            bus.frame_tick = 1'b0; go(); go();
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.mode_next = 1'b0; bus.frame_tick = 1'b0; bus.DE = 1'b1;
        bus.x_pixel = '0; bus.y_pixel = '0;
        set_sw(15, 15, 15);
        repeat (3) go();
        check_rgb("reset_rgb", 0, 0, 0);
        check("reset_mode", bus.mode, 0);

        reset = 1'b0; go();
        check_rgb("solid_fff", 15, 15, 15);
        bus.DE = 1'b0; go();
        check_rgb("de_low", 0, 0, 0);
        bus.DE = 1'b1;

        // Two requests in one frame -> one advance.
        bus.mode_next = 1'b1; go(); go();
        bus.mode_next = 1'b0; go(); go();
        bus.mode_next = 1'b1; go();
        bus.mode_next = 1'b0; go();
        bus.frame_tick = 1'b1; go();
        bus.frame_tick = 1'b0;
        check("bars_mode", bus.mode, 1);
        bus.x_pixel = 10'd0;   go(); check_rgb("bar_x0",   15, 15, 15);
        bus.x_pixel = 10'd80;  go(); check_rgb("bar_x80",  15, 15, 0);
        bus.x_pixel = 10'd639; go(); check_rgb("bar_x639", 0, 0, 0);

        bus.mode_next = 1'b1; go();
        bus.mode_next = 1'b0; bus.frame_tick = 1'b1; go();
        bus.frame_tick = 1'b0;
        check("checker_mode", bus.mode, 2);
        set_sw(3, 5, 10);
        bus.x_pixel = 10'd0;  bus.y_pixel = 10'd0;  go(); check_rgb("chk_0_0",   12, 10, 5);
        bus.x_pixel = 10'd32;                       go(); check_rgb("chk_32_0",  3, 5, 10);
        bus.y_pixel = 10'd32;                       go(); check_rgb("chk_32_32", 12, 10, 5);

        // Edge in the same cycle as the tick.
        bus.mode_next = 1'b1; bus.frame_tick = 1'b1; go();
        bus.mode_next = 1'b0; bus.frame_tick = 1'b0;
        check("same_cycle_mode", bus.mode, 3);

        set_sw(15, 8, 0);
        bus.x_pixel = 10'd100; bus.y_pixel = 10'd100;
        tick_frames(16);
        check_rgb("fade_lvl8", 7, 4, 0);
        tick_frames(16);
        check_rgb("fade_lvl14", 13, 7, 0);
        set_sw(15, 15, 15);
        tick_frames(32);
        check_rgb("fade_lvl2", 1, 1, 1);

        // Pending request and a held-high mode_next are both dropped by reset.
        bus.mode_next = 1'b1; go();
        reset = 1'b1; go(); go();
        check_rgb("midreset_rgb", 0, 0, 0);
        check("midreset_mode", bus.mode, 0);
        reset = 1'b0; go();
        bus.frame_tick = 1'b1; go();
        bus.frame_tick = 1'b0; go();
        check("no_adv_after_reset", bus.mode, 0);
        bus.mode_next = 1'b0; go();
        bus.mode_next = 1'b1; go();
        bus.frame_tick = 1'b1; go();
        bus.frame_tick = 1'b0;
        check("adv_after_refall", bus.mode, 1);

        for (int i = 0; i < 6000; i++) begin
            reset = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 24) == 0) bus.mode_next = ~bus.mode_next;
            bus.frame_tick = ($urandom_range(0, 11) == 0);
            bus.DE = ($urandom_range(0, 7) != 0);
            bus.x_pixel = 10'($urandom_range(0, 799));
            bus.y_pixel = 10'($urandom_range(0, 524));
            set_sw($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            go();
        end
        reset = 1'b0;
        go();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
